ro_puf_array_ctrl: RTL and testbench
====================================

RO_PUF_ARRAY_CTRL -- requirements
Module: ro_puf_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_RO, default 16, number of ring-oscillator channels (power of 2, >= 4).
REQ-002 SHALL have parameter CNT_W, default 16, edge-counter width.
REQ-003 SHALL have parameter WIN_W, default 16, measurement-window length width.
REQ-004 SHALL have parameter SETTLE_CYC, default 8, cycles between RO enable and count start.
REQ-005 SHALL derive IDX_W = clog2(NUM_RO) as a localparam.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports:
 clk_i  in  1  block clock
 rst_i  in  1  synchronous active-high reset
 req_i  in  1  challenge request
 ack_o  out  1  challenge accepted (1-cycle pulse)
 chal_i  in  2*IDX_W  [IDX_W-1:0]=index A, [2*IDX_W-1:IDX_W]=index B
 win_i  in  WIN_W  measurement window, clk cycles
 ro_en_o  out  NUM_RO  per-RO enable to oscillator array
 ro_i  in  NUM_RO  raw asynchronous RO outputs
 valid_o  out  1  result valid
 ready_i  in  1  result consumer ready
 resp_o  out  1  response bit
 tie_o  out  1  counts equal
 err_o  out  1  challenge rejected
 cnt_a_o  out  CNT_W  final count, RO A
 cnt_b_o  out  CNT_W  final count, RO B

Function
REQ-008 SHALL implement FSM states IDLE, SETTLE, COUNT, DRAIN, DONE.
REQ-009 In IDLE, req_i=1 SHALL pulse ack_o for one cycle and latch chal_i and win_i; req_i ignored in all other states.
REQ-010 Latched challenge with A==B or win_i==0 SHALL go directly IDLE->DONE with err_o=1, resp_o=0, tie_o=0, counts 0, ro_en_o never asserted.
REQ-011 Valid challenge: IDLE->SETTLE; ro_en_o SHALL have exactly bits A and B set from SETTLE entry through last COUNT cycle, all zero otherwise.
REQ-012 SETTLE SHALL last exactly SETTLE_CYC cycles; counters cleared to 0 during SETTLE.
REQ-013 Selected ro_i[A], ro_i[B] SHALL each pass a 2-flop synchronizer after the index mux; a rising edge = synchronized sample 1 with previous sample 0.
REQ-014 COUNT SHALL last exactly win (latched) cycles; each detected rising edge SHALL increment its counter.
REQ-015 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-016 DRAIN SHALL last 3 cycles; edges SHALL NOT be counted; ro_en_o all zero.
REQ-017 DONE: valid_o=1; resp_o = (cnt_a > cnt_b); tie_o = (cnt_a == cnt_b); err_o=0; outputs stable while valid_o=1 and ready_i=0.
REQ-018 valid_o=1 and ready_i=1 SHALL return to IDLE next cycle with valid_o=0; a new request is accepted no earlier than that IDLE cycle.
REQ-019 Counting correctness SHALL be specified only for RO frequency below clk_i/4.
REQ-020 Request-to-valid latency for a valid challenge SHALL be 1+SETTLE_CYC+win+3 cycles after the ack cycle.

Reset
REQ-021 rst_i=1 SHALL force IDLE, and on the next edge ack_o=0, valid_o=0, resp_o=0, tie_o=0, err_o=0, counts 0, ro_en_o all zero, synchronizers 0.
REQ-022 rst_i mid-measurement SHALL abort immediately (ro_en_o zero next cycle), no result produced.

Structure
REQ-023 FSM state enum and DRAIN length constant SHALL live in shared package ro_puf_pkg.
REQ-024 Synchronizer + edge detector + saturating counter SHALL be one sub-module ro_edge_counter, instantiated twice (A, B).
REQ-025 Oscillator array SHALL be external; this block contains no combinational loops.

Verification
REQ-026 NUM_RO=16, A=3, B=7, win=100, ro3 period 8 clk, ro7 period 10 clk -> ro_en_o=0x0088 during window, cnt_a~12, cnt_b~10, resp_o=1, tie_o=0.
REQ-027 A=5, B=5 -> ack_o pulse, valid_o next cycle, err_o=1, ro_en_o stays 0x0000.
REQ-028 CNT_W=4, win=200, ro period 4 clk -> cnt saturates at 15 both, tie_o=1, resp_o=0.
REQ-029 valid_o held with ready_i=0 for 20 cycles, req_i pulsed meanwhile -> outputs stable, no ack_o, IDLE only after ready_i=1.
REQ-030 rst_i asserted 5 cycles into COUNT -> ro_en_o=0 next cycle, valid_o never asserts, new request afterwards completes normally.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF controller: FSM state
// encoding and the post-window drain length.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    DRAIN,
    DONE
  } puf_state_e;

  localparam int unsigned DRAIN_CYC = 3;

endpackage

// File: rtl/ro_edge_counter.sv
// One measurement channel: 2-flop synchronizer on a raw RO output, rising-edge
// detector and a saturating edge counter.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise;

  assign rise = sync_q[1] & ~prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], ro_i};
      prev_q <= sync_q[1];
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_puf_array_ctrl.sv
// RO-PUF array controller: accepts a challenge (two RO indices + window),
// enables the pair, counts their edges and reports which one ran faster.
module ro_puf_array_ctrl
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO     = 16,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        ack_o,
  input  logic [2*$clog2(NUM_RO)-1:0] chal_i,
  input  logic [WIN_W-1:0]            win_i,
  output logic [NUM_RO-1:0]           ro_en_o,
  input  logic [NUM_RO-1:0]           ro_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        resp_o,
  output logic                        tie_o,
  output logic                        err_o,
  output logic [CNT_W-1:0]            cnt_a_o,
  output logic [CNT_W-1:0]            cnt_b_o
);

  localparam int IDX_W = $clog2(NUM_RO);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  puf_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]  chalA_q, chalA_d, chalB_q, chalB_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              err_q, err_d;
  logic [NUM_RO-1:0] roEn_q, roEn_d;
  logic [CNT_W-1:0]  cntA, cntB;
  logic              cntClr, cntEn;

  // One down-counting timer is reused for the SETTLE, COUNT and DRAIN phases.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    chalA_d = chalA_q;
    chalB_d = chalB_q;
    win_d   = win_q;
    err_d   = err_q;
    ack_o   = 1'b0;
    roEn_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (req_i && !rst_i) begin
          ack_o   = 1'b1;
          chalA_d = chal_i[IDX_W-1:0];
          chalB_d = chal_i[2*IDX_W-1:IDX_W];
          win_d   = win_i;
          if ((chal_i[IDX_W-1:0] == chal_i[2*IDX_W-1:IDX_W]) || (win_i == '0)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = SETTLE;
            timer_d = TMR_W'(SETTLE_CYC - 1);
          end
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = COUNT;
          timer_d = TMR_W'(win_q) - TMR_W'(1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      COUNT: begin
        if (timer_q == '0) begin
          state_d = DRAIN;
          timer_d = TMR_W'(DRAIN_CYC - 1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DRAIN: begin
        if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Enables are registered from the next state so ro_en_o is glitch-free.
    if ((state_d == SETTLE) || (state_d == COUNT)) begin
      roEn_d[chalA_d] = 1'b1;
      roEn_d[chalB_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      chalA_q <= '0;
      chalB_q <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
      roEn_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      chalA_q <= chalA_d;
      chalB_q <= chalB_d;
      win_q   <= win_d;
      err_q   <= err_d;
      roEn_q  <= roEn_d;
    end
  end

  assign cntClr = (state_q == IDLE) || (state_q == SETTLE);
  assign cntEn  = (state_q == COUNT);

  ro_edge_counter #(.CNT_W(CNT_W)) uCntA (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ro_i  (ro_i[chalA_q]),
    .clr_i (cntClr),
    .en_i  (cntEn),
    .cnt_o (cntA)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) uCntB (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ro_i  (ro_i[chalB_q]),
    .clr_i (cntClr),
    .en_i  (cntEn),
    .cnt_o (cntB)
  );

  assign ro_en_o = roEn_q;
  assign valid_o = (state_q == DONE);
  assign err_o   = valid_o && err_q;
  assign resp_o  = valid_o && !err_q && (cntA > cntB);
  assign tie_o   = valid_o && !err_q && (cntA == cntB);
  assign cnt_a_o = cntA;
  assign cnt_b_o = cntB;

endmodule

// File: tb/tb_ro_puf_array_ctrl.sv
// Randomized self-checking bench for ro_puf_array_ctrl; RO outputs are ideal
// square waves and expected counts come from counting their rising edges.
module tb_ro_puf_array_ctrl;

  localparam int NUM_RO  = 16;
  localparam int CNT_W   = 4;
  localparam int WIN_W   = 16;
  localparam int SETTLE  = 8;
  localparam int IDX_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SYNC_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 req_i = 1'b0;
  logic                 ack_o;
  logic [2*IDX_W-1:0]   chal_i = '0;
  logic [WIN_W-1:0]     win_i = '0;
  logic [NUM_RO-1:0]    ro_en_o;
  logic [NUM_RO-1:0]    ro_i = '0;
  logic                 valid_o;
  logic                 ready_i = 1'b0;
  logic                 resp_o;
  logic                 tie_o;
  logic                 err_o;
  logic [CNT_W-1:0]     cnt_a_o;
  logic [CNT_W-1:0]     cnt_b_o;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int period [NUM_RO];
  int phase  [NUM_RO];

  ro_puf_array_ctrl #(
    .NUM_RO(NUM_RO), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .ack_o(ack_o),
    .chal_i(chal_i), .win_i(win_i), .ro_en_o(ro_en_o), .ro_i(ro_i),
    .valid_o(valid_o), .ready_i(ready_i), .resp_o(resp_o), .tie_o(tie_o),
    .err_o(err_o), .cnt_a_o(cnt_a_o), .cnt_b_o(cnt_b_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic logic wave(input int ch, input int n);
    if (n < 0) return 1'b0;
    return ((n + phase[ch]) % period[ch]) < (period[ch] / 2);
  endfunction

  // Rising edges of the RO, seen SYNC_LAT cycles late, inside the window.
  function automatic int modelCount(input int ch, input int t0, input int w);
    int n = 0;
    for (int c = t0; c < t0 + w; c++) begin
      if (wave(ch, c - SYNC_LAT) && !wave(ch, c - SYNC_LAT - 1)) n++;
    end
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < NUM_RO; i++) ro_i[i] = wave(i, cycle);
  endtask

  task automatic randomizeRos();
    for (int i = 0; i < NUM_RO; i++) begin
      period[i] = $urandom_range(5, 24);
      phase[i]  = $urandom_range(0, 23);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_roen"}, 32'(ro_en_o), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_o), 32'd0);
    checkOutput({tag, "_resp"}, 32'(resp_o), 32'd0);
    checkOutput({tag, "_tie"}, 32'(tie_o), 32'd0);
  endtask

  // One full challenge: request, busy phase, DONE held for 'hold' cycles, handshake.
  task automatic applyStimulus(input int a, input int b, input int w, input int hold);
    int t0, total, expA, expB, mask;
    bit bad;
    tick();
    req_i  = 1'b1;
    chal_i = 8'((b << IDX_W) | a);
    win_i  = 16'(w);
    ready_i = 1'b0;
    #1;
    checkOutput("ack", 32'(ack_o), 32'd1);
    t0    = cycle;
    bad   = (a == b) || (w == 0);
    total = bad ? 1 : 1 + SETTLE + w + 3;
    mask  = bad ? 0 : ((1 << a) | (1 << b));
    expA  = bad ? 0 : modelCount(a, t0 + SETTLE + 1, w);
    expB  = bad ? 0 : modelCount(b, t0 + SETTLE + 1, w);
    for (int k = 1; k < total; k++) begin
      tick();
      req_i   = 1'($urandom);
      ready_i = 1'($urandom);
      chal_i  = 8'($urandom);
      win_i   = 16'($urandom);
      #1;
      checkOutput("roen", 32'(ro_en_o), (k <= SETTLE + w) ? 32'(mask) : 32'd0);
      checkOutput("valid_busy", 32'(valid_o), 32'd0);
      checkOutput("ack_busy", 32'(ack_o), 32'd0);
    end
    for (int h = 0; h <= hold; h++) begin
      tick();
      ready_i = (h == hold);
      req_i   = 1'($urandom);
      #1;
      checkOutput("valid", 32'(valid_o), 32'd1);
      checkOutput("ack_done", 32'(ack_o), 32'd0);
      checkOutput("err", 32'(err_o), 32'(bad));
      checkOutput("resp", 32'(resp_o), 32'(!bad && (expA > expB)));
      checkOutput("tie", 32'(tie_o), 32'(!bad && (expA == expB)));
      checkOutput("cnt_a", 32'(cnt_a_o), 32'(expA));
      checkOutput("cnt_b", 32'(cnt_b_o), 32'(expB));
      checkOutput("roen_done", 32'(ro_en_o), 32'd0);
    end
    tick();
    req_i   = 1'b0;
    ready_i = 1'b0;
    #1;
    checkOutput("valid_after", 32'(valid_o), 32'd0);
  endtask

  initial begin
    int a, b, w;
    for (int i = 0; i < NUM_RO; i++) begin
      period[i] = 8;
      phase[i]  = 0;
    end
    rst_i = 1'b1;
    req_i = 1'b1;
    repeat (3) tick();
    checkOutput("rst_ack", 32'(ack_o), 32'd0);
    checkIdleOutputs("rst");
    checkOutput("rst_cnt_a", 32'(cnt_a_o), 32'd0);
    checkOutput("rst_cnt_b", 32'(cnt_b_o), 32'd0);
    req_i = 1'b0;
    rst_i = 1'b0;
    tick();

    $display("[TB] directed: A=3 B=7 win=100");
    period[3] = 8;
    period[7] = 10;
    applyStimulus(3, 7, 100, 0);

    $display("[TB] directed: A==B rejected");
    applyStimulus(5, 5, 30, 0);
    $display("[TB] directed: zero window rejected");
    applyStimulus(2, 9, 0, 1);

    $display("[TB] directed: saturation with period-4 ROs");
    period[1] = 4;
    period[2] = 4;
    applyStimulus(1, 2, 200, 0);

    $display("[TB] directed: DONE held 20 cycles");
    applyStimulus(4, 11, 40, 20);

    $display("[TB] directed: reset during COUNT");
    tick();
    req_i  = 1'b1;
    chal_i = 8'((9 << IDX_W) | 2);
    win_i  = 16'd50;
    #1;
    checkOutput("abort_ack", 32'(ack_o), 32'd1);
    repeat (SETTLE + 5) begin
      tick();
      req_i = 1'b0;
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("abort_roen", 32'(ro_en_o), 32'd0);
    checkOutput("abort_valid", 32'(valid_o), 32'd0);
    for (int k = 0; k < 80; k++) begin
      tick();
      #1;
      if (valid_o !== 1'b0 || ro_en_o !== '0) checkOutput("abort_quiet", {15'd0, valid_o, ro_en_o}, 32'd0);
    end
    checkIdleOutputs("abort_end");
    applyStimulus(6, 13, 60, 2);

    $display("[TB] random challenges");
    for (int n = 0; n < 30; n++) begin
      randomizeRos();
      a = $urandom_range(0, NUM_RO - 1);
      b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, NUM_RO - 1);
      w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 120);
      applyStimulus(a, b, w, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
